// File: rtl/serial_popcount_acc.sv
// Serial popcount front-end: accepts one operand vector, counts its set bits one per cycle,
// and folds each count into a sticky-saturating running accumulator behind valid/ready ports.
module serial_popcount_acc #(
    parameter int N_IN  = 5,
    parameter int CNT_W = 3,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_cnt,
    output logic [ACC_W-1:0] out_acc,
    output logic             acc_sat
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [N_IN-1:0]    sreg_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [IDX_W-1:0]   idx_r;
    logic               last_s;
    logic               in_ready_s;
    logic               out_valid_s;
    logic [CNT_W-1:0]   out_cnt_r;
    logic [ACC_W-1:0]   out_acc_r;
    logic               acc_sat_r;
    logic [ACC_W-1:0]   acc_base_s;
    logic [ACC_W:0]     acc_sum_s;
    logic [ACC_W-1:0]   acc_upd_s;
    logic               sat_upd_s;

    // Widened add so the carry-out flags saturation.
    function automatic logic [ACC_W:0] add_ext(input logic [ACC_W-1:0] base,
                                               input logic [CNT_W-1:0] cnt);
        return {1'b0, base} + (ACC_W+1)'(cnt);
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = in_valid ? SHIFT : IDLE;
            SHIFT:   state_nxt_s = last_s ? OUT : SHIFT;
            OUT:     state_nxt_s = out_ready ? IDLE : OUT;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake outputs decode straight from the state register, so no input reaches them.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s  = 1'b1;
            SHIFT:   in_ready_s  = 1'b0;
            OUT:     out_valid_s = 1'b1;
            default: in_ready_s  = 1'b0;
        endcase
    end

    // Per-bit count step and saturating accumulator update; a coincident clear zeroes the base first.
    always_comb begin
        cnt_nxt_s  = cnt_r + CNT_W'(sreg_r[0]);
        last_s     = (state_r == SHIFT) && (idx_r == IDX_W'(N_IN - 1));
        acc_base_s = acc_clr ? {ACC_W{1'b0}} : out_acc_r;
        acc_sum_s  = add_ext(acc_base_s, cnt_nxt_s);
        acc_upd_s  = acc_sum_s[ACC_W] ? {ACC_W{1'b1}} : acc_sum_s[ACC_W-1:0];
        sat_upd_s  = (acc_clr ? 1'b0 : acc_sat_r) | acc_sum_s[ACC_W];
    end

    // Shift datapath: load on accept, consume LSB first while shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_r <= {N_IN{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            idx_r  <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sreg_r <= in_vec;
                        cnt_r  <= {CNT_W{1'b0}};
                        idx_r  <= {IDX_W{1'b0}};
                    end
                end
                SHIFT: begin
                    sreg_r <= {1'b0, sreg_r[N_IN-1:1]};
                    cnt_r  <= cnt_nxt_s;
                    idx_r  <= idx_r + IDX_W'(1);
                end
                default: begin
                    sreg_r <= sreg_r;
                end
            endcase
        end
    end

    // Result registers: held in OUT; only acc_clr may disturb them outside the final shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt_r <= {CNT_W{1'b0}};
            out_acc_r <= {ACC_W{1'b0}};
            acc_sat_r <= 1'b0;
        end else if (last_s) begin
            out_cnt_r <= cnt_nxt_s;
            out_acc_r <= acc_upd_s;
            acc_sat_r <= sat_upd_s;
        end else if (acc_clr) begin
            out_acc_r <= {ACC_W{1'b0}};
            acc_sat_r <= 1'b0;
        end else begin
            out_acc_r <= out_acc_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_cnt   = out_cnt_r;
    assign out_acc   = out_acc_r;
    assign acc_sat   = acc_sat_r;

endmodule
